// File: rtl/uart_pkg.sv
// Shared UART types and constants: line-control encodings, transmitter
// state encoding and small helpers derived from the word length.
package uart_pkg;

  // LCR[1:0] character length encoding.
  typedef enum logic [1:0] {
    WORD_LEN_5 = 2'b00,
    WORD_LEN_6 = 2'b01,
    WORD_LEN_7 = 2'b10,
    WORD_LEN_8 = 2'b11
  } word_len_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int TICKS_PER_BIT = 16;

  // Framing controls captured at the start of each frame.
  typedef struct packed {
    word_len_e word_len;
    logic      stop_bits;
    logic      parity_en;
    logic      parity_even;
    logic      parity_stick;
  } tx_cfg_t;

  // Mask selecting the bits of a character that are actually sent.
  function automatic logic [7:0] data_mask(input word_len_e wl);
    case (wl)
      WORD_LEN_5: data_mask = 8'h1F;
      WORD_LEN_6: data_mask = 8'h3F;
      WORD_LEN_7: data_mask = 8'h7F;
      default:    data_mask = 8'hFF;
    endcase
  endfunction

  // Index of the last data bit sent (4..7).
  function automatic logic [2:0] last_bit_idx(input word_len_e wl);
    last_bit_idx = 3'd4 + {1'b0, wl};
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Character handshake between the holding register/FIFO and the serializer.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, 5-8 data bits LSB first, optional
// parity and 1/1.5/2 stop bits, each bit lasting 16 baud ticks.
module uart_tx
  import uart_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      baud_tick,
  input  word_len_e word_len,
  input  logic      stop_bits,
  input  logic      parity_en,
  input  logic      parity_even,
  input  logic      parity_stick,
  input  logic      set_break,
  uart_tx_if.slave  tx_if,
  output logic      txd,
  output logic      tsr_empty
);

  tx_state_e   r_state,    w_state_nxt;
  logic [3:0]  r_tick_cnt, w_tick_nxt;
  logic [2:0]  r_bit_cnt,  w_bit_nxt;
  logic        r_txd,      w_txd_nxt;
  logic [7:0]  r_data;
  tx_cfg_t     r_cfg;
  logic        w_load;
  logic        w_bit_end;
  logic        w_half_end;
  logic        w_stop_end;
  logic        w_par_xor;
  logic        w_parity;

  assign w_bit_end  = baud_tick && (r_tick_cnt == 4'(TICKS_PER_BIT - 1));
  assign w_half_end = baud_tick && (r_tick_cnt == 4'(TICKS_PER_BIT / 2 - 1));

  // Stop period: one full bit, then either done (1 stop), half a bit more
  // (1.5 stop, 5-bit words only) or a second full bit (2 stop).
  assign w_stop_end = (r_bit_cnt == 3'd0 && !r_cfg.stop_bits && w_bit_end) ||
                      (r_bit_cnt == 3'd1 && r_cfg.word_len == WORD_LEN_5 && w_half_end) ||
                      (r_bit_cnt == 3'd1 && r_cfg.word_len != WORD_LEN_5 && w_bit_end);

  assign w_par_xor = ^(r_data & data_mask(r_cfg.word_len));
  assign w_parity  = r_cfg.parity_stick ? ~r_cfg.parity_even
                   : (r_cfg.parity_even ? w_par_xor : ~w_par_xor);

  assign tx_if.tx_ready = (r_state == IDLE);
  assign tsr_empty      = (r_state == IDLE);
  assign txd            = r_txd & ~set_break;

  // Next-state, counter and next-txd logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_txd_nxt   = r_txd;
    w_load      = 1'b0;

    if (r_state != IDLE && baud_tick) w_tick_nxt = r_tick_cnt + 4'd1;

    case (r_state)
      IDLE: begin
        w_txd_nxt = 1'b1;
        if (tx_if.tx_valid) begin
          w_load      = 1'b1;
          w_tick_nxt  = 4'd0;
          w_bit_nxt   = 3'd0;
          w_txd_nxt   = 1'b0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_bit_nxt   = 3'd0;
          w_txd_nxt   = r_data[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == last_bit_idx(r_cfg.word_len)) begin
            w_bit_nxt = 3'd0;
            if (r_cfg.parity_en) begin
              w_state_nxt = PARITY;
              w_txd_nxt   = w_parity;
            end else begin
              w_state_nxt = STOP;
              w_txd_nxt   = 1'b1;
            end
          end else begin
            w_bit_nxt = r_bit_cnt + 3'd1;
            w_txd_nxt = r_data[r_bit_cnt + 3'd1];
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_bit_nxt   = 3'd0;
          w_txd_nxt   = 1'b1;
        end
      end
      STOP: begin
        w_txd_nxt = 1'b1;
        if (w_stop_end) begin
          w_state_nxt = IDLE;
          w_tick_nxt  = 4'd0;
          w_bit_nxt   = 3'd0;
        end else if (w_bit_end) begin
          w_bit_nxt = 3'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  // State, counters and the registered serial output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tick_cnt <= 4'd0;
      r_bit_cnt  <= 3'd0;
      r_txd      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

  // Character and framing controls, captured once per frame.
  // NOTE: no reset here; these are always loaded before the FSM reads them.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_data <= tx_if.tx_data;
      r_cfg  <= '{word_len:     word_len,
                  stop_bits:    stop_bits,
                  parity_en:    parity_en,
                  parity_even:  parity_even,
                  parity_stick: parity_stick};
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: random baud ticks, a frame-level reference
// model and a scoreboard that compares every counted tick of every frame.
module tb_uart_tx;
  import uart_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      baud_tick;
  word_len_e word_len;
  logic      stop_bits, parity_en, parity_even, parity_stick, set_break;
  logic      txd, tsr_empty;

  uart_tx_if bus ();

  uart_tx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .baud_tick    (baud_tick),
    .word_len     (word_len),
    .stop_bits    (stop_bits),
    .parity_en    (parity_en),
    .parity_even  (parity_even),
    .parity_stick (parity_stick),
    .set_break    (set_break),
    .tx_if        (bus.slave),
    .txd          (txd),
    .tsr_empty    (tsr_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    word_len_e  wl;
    bit         sb, pen, pev, pst, b2b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   frames_sent = 0;
  int   frames_done = 0;
  int   aborted     = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: frame length and expected line level at tick t.
  function automatic int frame_ticks(input exp_t e);
    int n    = 5 + int'(e.wl);
    int stop = !e.sb ? 16 : (e.wl == WORD_LEN_5 ? 24 : 32);
    return 16 * (1 + n + (e.pen ? 1 : 0)) + stop;
  endfunction

  function automatic logic model_bit(input exp_t e, input int t);
    int n = 5 + int'(e.wl);
    int b = t / 16;
    int ones;
    if (b == 0) return 1'b0;
    if (b <= n) return e.data[b-1];
    if (e.pen && b == n + 1) begin
      ones = $countones(e.data & 8'((1 << n) - 1));
      if (e.pst) return ~e.pev;
      return e.pev ? logic'(ones % 2) : logic'(!(ones % 2));
    end
    return 1'b1;
  endfunction

  // Random 16x baud tick, changed just after each rising edge.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1 baud_tick = ($urandom_range(0, 2) == 0);
    end
  end

  // Monitor: frames are delimited by tsr_empty; each counted tick is compared.
  initial begin
    bit   in_frame = 0;
    exp_t cur;
    int   t = 0, werr = 0, gap = 0;
    logic e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 0;
        gap      = 0;
        continue;
      end
      if (!in_frame) begin
        if (!tsr_empty) begin
          in_frame = 1;
          t        = 0;
          werr     = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
            cur = '{data: 8'h00, wl: WORD_LEN_8, sb: 0, pen: 0, pev: 0, pst: 0, b2b: 0};
          end else begin
            cur = exp_q.pop_front();
          end
          if (cur.b2b) check("b2b_gap_cycles", gap, 1);
        end else begin
          gap++;
        end
      end
      if (in_frame) begin
        if (tsr_empty) begin
          check("frame_ticks", t, frame_ticks(cur));
          check("frame_wave_errs", werr, 0);
          check("idle_txd", int'(txd), int'(!set_break));
          frames_done++;
          in_frame = 0;
          gap      = 1;
        end else begin
          if (bus.tx_ready !== 1'b0) werr++;
          if (baud_tick) begin
            e = model_bit(cur, t) & ~set_break;
            if (txd !== e) begin
              if (werr == 0)
                $display("FAIL wave tick %0d of frame data=%02h: got %b, expected %b", t, cur.data, txd, e);
              werr++;
            end
            t++;
          end
        end
      end
    end
  end

  // Present one character; returns #1 after the transferring edge.
  task automatic send(input logic [7:0] d, input word_len_e wl, input bit sb, pen, pev, pst,
                      input bit hold, input bit b2b);
    int n = 0;
    bus.tx_data  = d;
    word_len     = wl;
    stop_bits    = sb;
    parity_en    = pen;
    parity_even  = pev;
    parity_stick = pst;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 5000) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 5000) begin
      check("ready_timeout", 0, 1);
      bus.tx_valid = 1'b0;
      return;
    end
    exp_q.push_back('{data: d, wl: wl, sb: sb, pen: pen, pev: pev, pst: pst, b2b: b2b});
    frames_sent++;
    @(posedge clk);
    #1;
    check("ready_drop_after_xfer", int'(bus.tx_ready), 0);
    check("start_bit_next_cycle", int'(txd), int'(!set_break ? 1'b0 : 1'b0));
    if (!hold) bus.tx_valid = 1'b0;
  endtask

  initial begin
    int k, cyc;
    rst_n = 1'b0;  bus.tx_valid = 1'b0;  bus.tx_data = 8'h00;
    word_len = WORD_LEN_8;  stop_bits = 0;  parity_en = 0;
    parity_even = 0;  parity_stick = 0;  set_break = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", int'(txd), 1);
    check("reset_tx_ready", int'(bus.tx_ready), 1);
    check("reset_tsr_empty", int'(tsr_empty), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(8'hA5, WORD_LEN_8, 0, 0, 0, 0, 0, 0);          // 8N1
    send(8'h35, WORD_LEN_7, 0, 1, 1, 0, 0, 0);          // 7E1
    send(8'h35, WORD_LEN_7, 0, 1, 0, 0, 0, 0);          // 7O1
    send(8'h1F, WORD_LEN_5, 1, 0, 0, 0, 0, 0);          // 5 bits, 1.5 stop
    send(8'hE9, WORD_LEN_6, 1, 0, 0, 0, 0, 0);          // 6 bits, 2 stop
    send(8'h55, WORD_LEN_8, 0, 0, 0, 0, 1, 0);          // held valid ...
    send(8'hAA, WORD_LEN_8, 0, 0, 0, 0, 0, 1);          // ... back-to-back

    // Break and config change in the middle of a frame.
    send(8'h5A, WORD_LEN_8, 0, 0, 0, 0, 0, 0);
    repeat (60) @(posedge clk);
    #1;
    word_len = WORD_LEN_5;  parity_en = 1;  parity_even = 1;  stop_bits = 1;
    set_break = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("break_txd_low", int'(txd), 0);
    set_break = 1'b0;
    send(8'hC3, WORD_LEN_5, 1, 1, 1, 0, 0, 0);
    send(8'h0F, WORD_LEN_6, 0, 1, 0, 1, 0, 0);          // stick parity -> 1

    // Reset in the middle of the data bits.
    send(8'h3C, WORD_LEN_8, 0, 0, 0, 0, 0, 0);
    k = 0;  cyc = 0;
    while (k < 24 && cyc < 2000) begin
      @(posedge clk);
      if (baud_tick) k++;
      #1 cyc++;
    end
    rst_n = 1'b0;
    aborted++;
    #1;
    check("midframe_reset_txd", int'(txd), 1);
    check("midframe_reset_ready", int'(bus.tx_ready), 1);
    check("midframe_reset_empty", int'(tsr_empty), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h96, WORD_LEN_8, 0, 1, 1, 0, 0, 0);

    // Random frames.
    for (int i = 0; i < 10; i++) begin
      send(8'($urandom), word_len_e'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom_range(0, 3) == 0), 0, 0);
    end

    cyc = 0;
    while ((exp_q.size() != 0 || !tsr_empty) && cyc < 5000) begin
      @(posedge clk);
      #1 cyc++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("frames_completed", frames_done, frames_sent - aborted);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
